// File: rtl/stopwatch_timebase.sv
// Stopwatch timekeeping core: 10 ms prescaler, cascaded cs/s/min/h counters,
// start/stop, lap snapshot and clear control. All outputs are binary.
module stopwatch_timebase #(
    parameter int TICK_DIV = 1_000_000,
    parameter int HOUR_MAX = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic [7:0] centisec,
    output logic       running,
    output logic       lap_active
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]      HOUR_LAST  = 8'(HOUR_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_PAUSE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ss_q, r_lap_q, r_clr_q;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_hr, r_min, r_sec, r_cs;
    logic [7:0]    r_snap_hr, r_snap_min, r_snap_sec, r_snap_cs;

    logic w_raw_ss, w_ev_clr, w_ev_ss, w_ev_lap;
    logic w_counting, w_tick, w_clear_cnt, w_take_snap;

    // Button events with priority clear > start_stop > lap
    always_comb begin
        w_ev_clr    = clear & ~r_clr_q;
        w_raw_ss    = start_stop & ~r_ss_q;
        w_ev_ss     = w_raw_ss & ~w_ev_clr;
        w_ev_lap    = lap & ~r_lap_q & ~w_ev_clr & ~w_raw_ss;
        w_counting  = (r_state == S_RUN) || (r_state == S_LAP);
        w_tick      = w_counting && (r_presc == PRESC_LAST);
        w_clear_cnt = (r_state == S_PAUSE) && w_ev_clr;
        w_take_snap = (r_state == S_RUN) && w_ev_lap;
    end

    // Button level registers for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_q  <= 1'b0;
            r_lap_q <= 1'b0;
            r_clr_q <= 1'b0;
        end else begin
            r_ss_q  <= start_stop;
            r_lap_q <= lap;
            r_clr_q <= clear;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic, status flags and live/snapshot output mux
    always_comb begin
        w_state_nxt = r_state;
        running     = 1'b0;
        lap_active  = 1'b0;
        hours       = r_hr;
        minutes     = r_min;
        seconds     = r_sec;
        centisec    = r_cs;
        case (r_state)
            S_IDLE: begin
                if (w_ev_ss) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                running = 1'b1;
                if (w_ev_ss)       w_state_nxt = S_PAUSE;
                else if (w_ev_lap) w_state_nxt = S_LAP;
            end
            S_LAP: begin
                running    = 1'b1;
                lap_active = 1'b1;
                hours      = r_snap_hr;
                minutes    = r_snap_min;
                seconds    = r_snap_sec;
                centisec   = r_snap_cs;
                if (w_ev_ss)       w_state_nxt = S_PAUSE;
                else if (w_ev_lap) w_state_nxt = S_RUN;
            end
            S_PAUSE: begin
                if (w_ev_ss)       w_state_nxt = S_RUN;
                else if (w_ev_clr) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Prescaler: advances only while counting, holds its phase across a pause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_clear_cnt) begin
            r_presc <= '0;
        end else if (w_counting) begin
            if (r_presc == PRESC_LAST) r_presc <= '0;
            else                       r_presc <= r_presc + PW'(1);
        end
    end

    // Cascaded live counters, full silent wrap after HOUR_MAX:59:59.99
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hr  <= '0;
            r_min <= '0;
            r_sec <= '0;
            r_cs  <= '0;
        end else if (w_clear_cnt) begin
            r_hr  <= '0;
            r_min <= '0;
            r_sec <= '0;
            r_cs  <= '0;
        end else if (w_tick) begin
            if (r_cs == 8'd99) begin
                r_cs <= '0;
                if (r_sec == 8'd59) begin
                    r_sec <= '0;
                    if (r_min == 8'd59) begin
                        r_min <= '0;
                        if (r_hr == HOUR_LAST) r_hr <= '0;
                        else                   r_hr <= r_hr + 8'd1;
                    end else begin
                        r_min <= r_min + 8'd1;
                    end
                end else begin
                    r_sec <= r_sec + 8'd1;
                end
            end else begin
                r_cs <= r_cs + 8'd1;
            end
        end
    end

    // Lap snapshot captures the live count before any same-edge increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_hr  <= '0;
            r_snap_min <= '0;
            r_snap_sec <= '0;
            r_snap_cs  <= '0;
        end else if (w_take_snap) begin
            r_snap_hr  <= r_hr;
            r_snap_min <= r_min;
            r_snap_sec <= r_sec;
            r_snap_cs  <= r_cs;
        end
    end

endmodule
